// File: rtl/exu_mul_pipe.sv
// exu_mul_pipe: parametrised, fully pipelined integer multiplier for the EXU.
// Ports:
//   clk, rst_l (sync, active-low)
//   freeze     holds every stage
//   flush      kills in-flight ops and any op presented this cycle
//   in_valid   op issue strobe
//   rs1_sign / rs2_sign / low / in_tag / a / b   op fields
//   rs1_byp_sel / rs2_byp_sel   0=a/b, 1=lsu, 2=vp, 3=a/b
//   lsu_result / rs*_vp_result  late bypass data, live in stage 1
//   out_valid / out_tag / out   result bundle (zeroed when invalid)
//   busy       any stage holds a valid op
module exu_mul_pipe #(
    parameter int XLEN       = 32,
    parameter int NUM_STAGES = 3,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             freeze,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             rs1_sign,
    input  logic             rs2_sign,
    input  logic             low,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [1:0]       rs1_byp_sel,
    input  logic [1:0]       rs2_byp_sel,
    input  logic [XLEN-1:0]  lsu_result,
    input  logic [XLEN-1:0]  rs1_vp_result,
    input  logic [XLEN-1:0]  rs2_vp_result,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic [XLEN-1:0]  out,
    output logic             busy
);

    // Number of product registers behind the operand register.
    localparam int NP = NUM_STAGES - 2;
    localparam int PW = 2 * XLEN;

    // Stage 0: input register
    logic             s0_valid;
    logic [XLEN-1:0]  s0_a;
    logic [XLEN-1:0]  s0_b;
    logic             s0_rs1_sign;
    logic             s0_rs2_sign;
    logic             s0_low;
    logic [TAG_W-1:0] s0_tag;
    logic [1:0]       s0_sel1;
    logic [1:0]       s0_sel2;

    // Stage 1 -> 2: extended operand register
    logic             s1_valid;
    logic [XLEN:0]    s1_opa;
    logic [XLEN:0]    s1_opb;
    logic             s1_low;
    logic [TAG_W-1:0] s1_tag;

    // Product registers
    logic [NP-1:0]    p_valid;
    logic [NP-1:0]    p_low;
    logic [PW-1:0]    p_data [NP];
    logic [TAG_W-1:0] p_tag  [NP];

    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [XLEN:0]    opa;
    logic [XLEN:0]    opb;
    logic [PW-1:0]    ext_a;
    logic [PW-1:0]    ext_b;
    logic [PW-1:0]    prod;
    logic             take;

    assign take = in_valid & ~freeze & ~flush;

    // Late bypass: load / VP data arrive the cycle after issue.
    always_comb begin
        op1 = s0_a;
        case (s0_sel1)
            2'd1:    op1 = lsu_result;
            2'd2:    op1 = rs1_vp_result;
            default: op1 = s0_a;
        endcase
    end

    always_comb begin
        op2 = s0_b;
        case (s0_sel2)
            2'd1:    op2 = lsu_result;
            2'd2:    op2 = rs2_vp_result;
            default: op2 = s0_b;
        endcase
    end

    assign opa = {s0_rs1_sign & op1[XLEN-1], op1};
    assign opb = {s0_rs2_sign & op2[XLEN-1], op2};

    // Low 2*XLEN bits of the signed (XLEN+1)-bit product equal the
    // product of the operands sign-extended to 2*XLEN bits.
    assign ext_a = {{(XLEN-1){s1_opa[XLEN]}}, s1_opa};
    assign ext_b = {{(XLEN-1){s1_opb[XLEN]}}, s1_opb};
    assign prod  = ext_a * ext_b;

    // Valid chain: clocks every cycle; flush beats freeze.
    always_ff @(posedge clk) begin
        if (!rst_l || flush) begin
            s0_valid <= 1'b0;
            s1_valid <= 1'b0;
            p_valid  <= '0;
        end else if (!freeze) begin
            s0_valid   <= in_valid;
            s1_valid   <= s0_valid;
            p_valid[0] <= s1_valid;
            for (int i = 1; i < NP; i++) begin
                p_valid[i] <= p_valid[i-1];
            end
        end
    end

    // Data chain: enable-style flops, loaded only behind a valid op.
    always_ff @(posedge clk) begin
        if (!freeze) begin
            if (take) begin
                s0_a        <= a;
                s0_b        <= b;
                s0_rs1_sign <= rs1_sign;
                s0_rs2_sign <= rs2_sign;
                s0_low      <= low;
                s0_tag      <= in_tag;
                s0_sel1     <= rs1_byp_sel;
                s0_sel2     <= rs2_byp_sel;
            end
            if (s0_valid) begin
                s1_opa <= opa;
                s1_opb <= opb;
                s1_low <= s0_low;
                s1_tag <= s0_tag;
            end
            if (s1_valid) begin
                p_data[0] <= prod;
                p_low[0]  <= s1_low;
                p_tag[0]  <= s1_tag;
            end
            for (int i = 1; i < NP; i++) begin
                if (p_valid[i-1]) begin
                    p_data[i] <= p_data[i-1];
                    p_low[i]  <= p_low[i-1];
                    p_tag[i]  <= p_tag[i-1];
                end
            end
        end
    end

    assign out_valid = p_valid[NP-1];
    assign out_tag   = out_valid ? p_tag[NP-1] : '0;
    assign out       = !out_valid    ? '0 :
                       p_low[NP-1]   ? p_data[NP-1][XLEN-1:0] :
                                       p_data[NP-1][PW-1:XLEN];
    assign busy      = s0_valid | s1_valid | (|p_valid);

endmodule

// File: tb/tb_exu_mul_pipe.sv
// tb_exu_mul_pipe: directed scoreboard bench for exu_mul_pipe.
// Checks a 32-bit/3-stage instance and a 64-bit/5-stage instance.
module tb_exu_mul_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // 32-bit, 3-stage instance
    logic        rst_l, freeze, flush, in_valid;
    logic        rs1_sign, rs2_sign, low;
    logic [4:0]  in_tag;
    logic [31:0] a, b, lsu_result, rs1_vp_result, rs2_vp_result;
    logic [1:0]  rs1_byp_sel, rs2_byp_sel;
    logic        out_valid, busy;
    logic [4:0]  out_tag;
    logic [31:0] out;

    exu_mul_pipe #(.XLEN(32), .NUM_STAGES(3), .TAG_W(5)) dut (
        .clk(clk), .rst_l(rst_l), .freeze(freeze), .flush(flush),
        .in_valid(in_valid), .rs1_sign(rs1_sign), .rs2_sign(rs2_sign),
        .low(low), .in_tag(in_tag), .a(a), .b(b),
        .rs1_byp_sel(rs1_byp_sel), .rs2_byp_sel(rs2_byp_sel),
        .lsu_result(lsu_result), .rs1_vp_result(rs1_vp_result),
        .rs2_vp_result(rs2_vp_result), .out_valid(out_valid),
        .out_tag(out_tag), .out(out), .busy(busy)
    );

    // 64-bit, 5-stage instance
    logic        x_rst_l, x_freeze, x_flush, x_in_valid;
    logic        x_rs1_sign, x_rs2_sign, x_low;
    logic [4:0]  x_in_tag;
    logic [63:0] x_a, x_b, x_lsu, x_vp1, x_vp2;
    logic [1:0]  x_sel1, x_sel2;
    logic        x_out_valid, x_busy;
    logic [4:0]  x_out_tag;
    logic [63:0] x_out;

    exu_mul_pipe #(.XLEN(64), .NUM_STAGES(5), .TAG_W(5)) dut64 (
        .clk(clk), .rst_l(x_rst_l), .freeze(x_freeze), .flush(x_flush),
        .in_valid(x_in_valid), .rs1_sign(x_rs1_sign),
        .rs2_sign(x_rs2_sign), .low(x_low), .in_tag(x_in_tag),
        .a(x_a), .b(x_b), .rs1_byp_sel(x_sel1), .rs2_byp_sel(x_sel2),
        .lsu_result(x_lsu), .rs1_vp_result(x_vp1),
        .rs2_vp_result(x_vp2), .out_valid(x_out_valid),
        .out_tag(x_out_tag), .out(x_out), .busy(x_busy)
    );

    typedef struct packed {
        logic [4:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   pop_cyc [32];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid    = 1'b0;
        rs1_byp_sel = 2'd0;
        rs2_byp_sel = 2'd0;
    endtask

    task automatic send(input logic [4:0] t, input logic [31:0] av,
                        input logic [31:0] bv, input logic s1,
                        input logic s2, input logic lo,
                        input logic [1:0] se1, input logic [1:0] se2,
                        input logic [31:0] e, input bit push);
        in_valid    = 1'b1;
        in_tag      = t;
        a           = av;
        b           = bv;
        rs1_sign    = s1;
        rs2_sign    = s2;
        low         = lo;
        rs1_byp_sel = se1;
        rs2_byp_sel = se2;
        if (push) q.push_back(exp_t'{tag: t, data: e});
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    // Scoreboard: compare whenever a result is shown; consume it
    // only in a cycle that is not frozen.
    always @(negedge clk) begin
        if (rst_l && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 64'(out_valid), 64'd0);
            end else begin
                chk("sb_tag", 64'(out_tag), 64'(q[0].tag));
                chk("sb_data", 64'(out), 64'(q[0].data));
                if (!freeze) begin
                    pop_cyc[out_tag] = cyc;
                    void'(q.pop_front());
                end
            end
        end
    end

    int c1;

    initial begin
        rst_l = 1'b0; freeze = 1'b0; flush = 1'b0;
        idle();
        rs1_sign = 1'b0; rs2_sign = 1'b0; low = 1'b0; in_tag = '0;
        a = '0; b = '0;
        lsu_result = '0; rs1_vp_result = '0; rs2_vp_result = '0;
        x_rst_l = 1'b0; x_freeze = 1'b0; x_flush = 1'b0;
        x_in_valid = 1'b0; x_rs1_sign = 1'b0; x_rs2_sign = 1'b0;
        x_low = 1'b0; x_in_tag = '0; x_a = '0; x_b = '0;
        x_lsu = '0; x_vp1 = '0; x_vp2 = '0;
        x_sel1 = '0; x_sel2 = '0;
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_x_out_valid", 64'(x_out_valid), 64'd0);
        chk("rst_x_busy", 64'(x_busy), 64'd0);
        rst_l = 1'b1;
        x_rst_l = 1'b1;
        tick();

        // Latency: signed low, 7 * -3
        send(5'd5, 32'd7, 32'hFFFF_FFFD, 1, 1, 1, 0, 0,
             32'hFFFF_FFEB, 1);
        tick();
        idle();
        chk("lat_e0_valid", 64'(out_valid), 64'd0);
        chk("lat_e0_busy", 64'(busy), 64'd1);
        tick();
        chk("lat_e1_valid", 64'(out_valid), 64'd0);
        tick();
        chk("lat_e2_valid", 64'(out_valid), 64'd1);
        chk("lat_e2_out", 64'(out), 64'hFFFF_FFEB);
        chk("lat_e2_tag", 64'(out_tag), 64'd5);
        tick();
        chk("lat_idle_busy", 64'(busy), 64'd0);

        // Back-to-back sign/half variants
        send(5'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0,
             32'hFFFF_FFFE, 1);
        tick();
        send(5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 0, 0,
             32'hFFFF_FFFF, 1);
        tick();
        send(5'd8, 32'h8000_0000, 32'h8000_0000, 1, 1, 0, 0, 0,
             32'h4000_0000, 1);
        tick();
        send(5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 1, 0, 0,
             32'h0000_0001, 1);
        tick();
        send(5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 0, 0,
             32'h0000_0001, 1);
        tick();
        idle();
        drain();

        // Late bypass: lsu on rs1
        lsu_result = 32'd100;
        send(5'd11, 32'd0, 32'd6, 0, 0, 1, 2'd1, 2'd0, 32'd30, 1);
        tick();
        idle();
        lsu_result = 32'd5;
        tick();
        lsu_result = 32'hDEAD;
        drain();

        // Late bypass: VP on rs2
        rs2_vp_result = 32'd50;
        send(5'd12, 32'd3, 32'd1000, 0, 0, 1, 2'd0, 2'd2, 32'd27, 1);
        tick();
        idle();
        rs2_vp_result = 32'd9;
        tick();
        rs2_vp_result = 32'd77;
        drain();

        // Late bypass: VP on rs1, signed value
        send(5'd14, 32'd0, 32'd7, 1, 1, 1, 2'd2, 2'd0,
             32'hFFFF_FFF2, 1);
        tick();
        idle();
        rs1_vp_result = 32'hFFFF_FFFE;
        tick();
        rs1_vp_result = 32'd0;
        drain();

        // Reserved select falls back to the register operand
        lsu_result = 32'd77;
        rs1_vp_result = 32'd88;
        send(5'd13, 32'd4, 32'd5, 0, 0, 1, 2'd3, 2'd3, 32'd20, 1);
        tick();
        idle();
        tick();
        drain();

        // Freeze for 2 cycles while tag 2 sits in the operand stage
        send(5'd1, 32'd2, 32'd3, 0, 0, 1, 0, 0, 32'd6, 1);
        tick();
        c1 = cyc;
        send(5'd2, 32'd10, 32'd10, 0, 0, 1, 0, 0, 32'd100, 1);
        tick();
        send(5'd3, 32'hFFFF_FFFF, 32'd5, 1, 1, 1, 0, 0,
             32'hFFFF_FFFB, 1);
        tick();
        freeze = 1'b1;
        send(5'd4, 32'h1234_5678, 32'd1, 0, 0, 1, 0, 0,
             32'h1234_5678, 0);
        tick();
        chk("frz_valid", 64'(out_valid), 64'd1);
        chk("frz_out", 64'(out), 64'd6);
        tick();
        chk("frz_out_hold", 64'(out), 64'd6);
        freeze = 1'b0;
        send(5'd4, 32'h1234_5678, 32'd1, 0, 0, 1, 0, 0,
             32'h1234_5678, 1);
        tick();
        idle();
        drain();
        for (int t = 1; t <= 4; t++)
            chk("frz_pop_cycle", 64'(pop_cyc[t]), 64'(c1 + 3 + t));

        // Flush with 3 ops in flight plus a fresh issue
        send(5'd20, 32'd2, 32'd3, 0, 0, 1, 0, 0, 32'd6, 1);
        tick();
        send(5'd21, 32'd4, 32'd4, 0, 0, 1, 0, 0, 32'd16, 0);
        tick();
        send(5'd22, 32'd5, 32'd5, 0, 0, 1, 0, 0, 32'd25, 0);
        tick();
        flush = 1'b1;
        send(5'd23, 32'd6, 32'd6, 0, 0, 1, 0, 0, 32'd36, 0);
        tick();
        flush = 1'b0;
        idle();
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_busy", 64'(busy), 64'd0);
        repeat (6) tick();
        chk("flush_queue", 64'(q.size()), 64'd0);

        // Flush dominates freeze
        send(5'd24, 32'd3, 32'd3, 0, 0, 1, 0, 0, 32'd9, 0);
        tick();
        idle();
        freeze = 1'b1;
        flush = 1'b1;
        tick();
        freeze = 1'b0;
        flush = 1'b0;
        chk("flfrz_busy", 64'(busy), 64'd0);
        repeat (4) tick();
        chk("flfrz_valid", 64'(out_valid), 64'd0);

        // 64-bit, 5 stages: MULH -1 * 2
        x_in_valid = 1'b1;
        x_a = 64'hFFFF_FFFF_FFFF_FFFF;
        x_b = 64'd2;
        x_rs1_sign = 1'b1;
        x_rs2_sign = 1'b1;
        x_low = 1'b0;
        x_in_tag = 5'd3;
        tick();
        x_in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("x_lat_valid_low", 64'(x_out_valid), 64'd0);
        end
        tick();
        chk("x_lat_valid", 64'(x_out_valid), 64'd1);
        chk("x_out", x_out, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("x_tag", 64'(x_out_tag), 64'd3);
        tick();
        chk("x_idle_busy", 64'(x_busy), 64'd0);

        // Reset mid-flight discards the op
        x_in_valid = 1'b1;
        x_a = 64'd5;
        x_b = 64'd6;
        x_low = 1'b1;
        x_in_tag = 5'd9;
        tick();
        x_in_valid = 1'b0;
        repeat (3) tick();
        chk("x_mid_busy", 64'(x_busy), 64'd1);
        x_rst_l = 1'b0;
        tick();
        chk("x_rst_valid", 64'(x_out_valid), 64'd0);
        chk("x_rst_out", x_out, 64'd0);
        chk("x_rst_tag", 64'(x_out_tag), 64'd0);
        chk("x_rst_busy", 64'(x_busy), 64'd0);
        x_rst_l = 1'b1;
        repeat (3) tick();
        chk("x_post_rst_valid", 64'(x_out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exu_mul_pipe.md
Name: exu_mul_pipe

Overview:
- Parametrised, fully pipelined integer multiplier for the EXU; successor to the fixed 32-bit, 3-stage multiply unit.
- Generalises operand width and pipeline depth.
- Adds per-op tag tracking, flush/kill, an output valid and a busy indication.
- Bypass selection covers load-result and value-prediction (VP) sources.
- Sits beside the ALUs; takes decode-stage operands and returns the result to the writeback/commit path.

Parameters:
XLEN, 32, operand and result width (16, 32 or 64).
NUM_STAGES, 3, latency in cycles from in_valid to out_valid; legal range 3..6.
TAG_W, 5, width of the destination/op tag carried alongside each op.

Ports:
clk  in  1  core clock
rst_l  in  1  synchronous active-low reset
freeze  in  1  pipeline freeze: all stages hold
flush  in  1  kill every in-flight op and any op presented this cycle
in_valid  in  1  op presented this cycle
rs1_sign  in  1  treat rs1 as signed
rs2_sign  in  1  treat rs2 as signed
low  in  1  1 = return low XLEN bits; 0 = return high XLEN bits
in_tag  in  TAG_W  tag for this op
a  in  XLEN  rs1 operand
b  in  XLEN  rs2 operand
rs1_byp_sel  in  2  0 = a, 1 = lsu_result, 2 = rs1_vp_result, 3 = reserved (treated as 0); sampled with in_valid
rs2_byp_sel  in  2  same encoding for rs2
lsu_result  in  XLEN  late load data, consumed in stage 1
rs1_vp_result  in  XLEN  VP value for rs1, consumed in stage 1
rs2_vp_result  in  XLEN  VP value for rs2, consumed in stage 1
out_valid  out  1  result valid
out_tag  out  TAG_W  tag of the result
out  out  XLEN  result
busy  out  1  any stage holds a valid op

Behaviour:
- Reset (rst_l=0 at a clk edge): all stage valids, out_valid, out_tag, out and busy go to 0. Data registers need no reset but must never propagate while invalid. Reset mid-operation discards every in-flight op.
- Stage 0, input register: on in_valid & ~freeze & ~flush, capture a, b, sign bits, low, tag and the bypass selects.
- Stage 1 logic:
  - Select each operand per its byp_sel from the live lsu_result / vp_result inputs (late bypass; these inputs are valid in the cycle after issue).
  - Form the (XLEN+1)-bit operands as {sign & msb, operand}.
  - Register the operands into stage 2.
- Stage 2: full signed (XLEN+1)x(XLEN+1) product; keep bits [2*XLEN-1:0].
  - Register through NUM_STAGES-2 product registers; the extra registers (NUM_STAGES>3) allow retiming.
  - The final register feeds out.
- Result selection: out = low ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN] when out_valid, else 0. out_tag is 0 when out_valid=0.
- Latency: an op accepted at edge N produces out_valid=1 during the cycle following edge N+NUM_STAGES-1 (NUM_STAGES=3 matches the legacy timing). Throughput is one op per cycle; back-to-back ops stay independent.
- Freeze: every register, including valids, holds. out and out_valid stay stable for the whole freeze. in_valid is ignored while freeze=1; the issuing stage must re-present the op.
- Flush: at the next edge all valids clear, regardless of freeze (flush dominates freeze). An op presented in the same cycle as flush is dropped. The result on out in the flush cycle is still delivered; the consumer owns kill of that cycle.
- busy = OR of all stage valids, registered view (combinational from valid flops).
- Per-stage clock enables = (stage valid | clk_override-equivalent not required) & ~freeze. Data flops use enable-style flops; valid flops clock every cycle.
- Widths:
  - Signed x unsigned (MULHSU) uses rs1_sign=1, rs2_sign=0.
  - MUL ignores the sign bits for the low half.
  - No overflow flag.

Test Plan:
- XLEN=32, NUM_STAGES=3, low=1, signed, a=7, b=0xFFFFFFFD, issue at cycle 0 -> out_valid at cycle 3, out=0xFFFFFFEB, out_tag=in_tag.
- MULHU a=b=0xFFFFFFFF -> out=0xFFFFFFFE. MULHSU a=0xFFFFFFFF (signed), b=0xFFFFFFFF (unsigned) -> out=0xFFFFFFFF. MULH 0x80000000*0x80000000 -> out=0x40000000.
- Issue an op with rs1_byp_sel=1, a=0, lsu_result=5 in cycle 1, b=6 -> out=30. Repeat with rs2_byp_sel=2, rs2_vp_result=9, a=3 -> out=27.
- Four back-to-back ops with tags 1..4; freeze asserted for 2 cycles while tag 2 is in stage 2 -> results appear in order 1..4, each 2 cycles late, out held stable during freeze.
- Flush asserted with 3 ops in flight plus in_valid=1 -> out_valid=0 from the next cycle, busy=0, no later results.
- XLEN=64, NUM_STAGES=5, a=0xFFFFFFFFFFFFFFFF, b=2, signed, low=0 -> out=0xFFFFFFFFFFFFFFFF at cycle 5. Assert rst_l=0 mid-flight -> out_valid, out and busy are 0 after the edge.
